// File: rtl/spike_dec_pkg.sv
// Shared types and constants for the spike rate decoder: FSM state encoding,
// default field width and the saturation ceiling for that width.
package spike_dec_pkg;

  localparam int CNT_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] SAT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter: clear wins over increment; holds at MAX.
module sat_counter
  import spike_dec_pkg::*;
#(
  parameter int W = CNT_W_DEF,
  parameter logic [W-1:0] MAX = W'(SAT_MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over back-to-back windows of win_len+1 cycles and reports the
// spike count plus the most recent inter-spike interval through a valid/ready port.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  input  logic [CNT_W-1:0] win_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] rate,
  output logic [CNT_W-1:0] isi,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] win_cnt, spk_cnt, isi_cnt;
  logic [CNT_W-1:0] isi_last;
  logic [CNT_W-1:0] rate_now, isi_sum, isi_now;
  logic             running, win_end, win_clr, isi_clr;

  // running: this cycle belongs to a live window (RUN and not being torn down)
  assign running = (state == RUN) && en;
  assign win_end = running && (win_cnt == win_q);
  assign win_clr = !running || win_end;
  assign isi_clr = !running || spike;

  assign rate_now = (spike && (spk_cnt != CNT_MAX)) ? spk_cnt + 1'b1 : spk_cnt;
  assign isi_sum  = (isi_cnt == CNT_MAX) ? CNT_MAX : isi_cnt + 1'b1;
  assign isi_now  = spike ? isi_sum : isi_last;

  assign busy = (state == RUN);

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (win_clr),
    .inc   (running),
    .count (win_cnt)
  );

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_spk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (win_clr),
    .inc   (spike),
    .count (spk_cnt)
  );

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_isi_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (isi_clr),
    .inc   (1'b1),
    .count (isi_cnt)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en)  state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output port: a result is transferred on a cycle where out_valid and
  // out_ready are both high; while out_valid is high rate/isi do not change
  // until after that transfer, and a result that finds the register still
  // occupied (valid && !ready) is dropped and recorded in sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_q     <= '0;
      isi_last  <= '0;
      rate      <= '0;
      isi       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      if (((state == IDLE) && en) || win_end) begin
        win_q <= win_len;
      end
      if (running && spike) begin
        isi_last <= isi_sum;
      end
      if (win_end && (!out_valid || out_ready)) begin
        rate      <= rate_now;
        isi       <= isi_now;
        out_valid <= 1'b1;
      end else if (win_end) begin
        overrun <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed scenario bench for spike_rate_decoder with hand-computed expectations.
module tb_spike_rate_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spike;
  logic [7:0] win_len;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] rate;
  logic [7:0] isi;
  logic       overrun;
  logic       busy;

  int passed = 0;
  int total  = 0;

  spike_rate_decoder #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike     (spike),
    .win_len   (win_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .rate      (rate),
    .isi       (isi),
    .overrun   (overrun),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; spike = 1'b0; out_ready = 1'b0; win_len = 8'd0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; spike = 1'b1; out_ready = 1'b0; win_len = 8'd5;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", out_valid); else passed++;
    total++; if (rate !== 8'd0) $display("FAIL rst_rate: got %0d expected 0", rate); else passed++;
    total++; if (isi !== 8'd0) $display("FAIL rst_isi: got %0d expected 0", isi); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %0b expected 0", overrun); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_periodic();
    int n;
    do_reset();
    win_len = 8'd7; spike = 1'b1; out_ready = 1'b1; en = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 9) $display("FAIL per_latency: got %0d expected 9", n); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL per_busy: got %0b expected 1", busy); else passed++;
    total++; if (rate !== 8'd8) $display("FAIL per_rate: got %0d expected 8", rate); else passed++;
    total++; if (isi !== 8'd1) $display("FAIL per_isi: got %0d expected 1", isi); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL per_consumed: got %0b expected 0", out_valid); else passed++;
    n = 1;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 8) $display("FAIL per_period: got %0d expected 8", n); else passed++;
    total++; if (rate !== 8'd8) $display("FAIL per_rate2: got %0d expected 8", rate); else passed++;
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    win_len = 8'd255; spike = 1'b1; out_ready = 1'b1; en = 1'b1;
    n = 0;
    while (!out_valid && n < 400) begin tick(); n++; end
    total++; if (n !== 257) $display("FAIL sat_latency: got %0d expected 257", n); else passed++;
    total++; if (rate !== 8'd255) $display("FAIL sat_rate: got %0d expected 255", rate); else passed++;
    total++; if (isi !== 8'd1) $display("FAIL sat_isi: got %0d expected 1", isi); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL sat_overrun: got %0b expected 0", overrun); else passed++;
  endtask

  task automatic test_sparse();
    int nres;
    do_reset();
    win_len = 8'd15; out_ready = 1'b1; en = 1'b1;
    nres = 0;
    for (int e = 1; e <= 50; e++) begin
      spike = (e >= 2) && (((e - 2) % 4) == 0);
      tick();
      if (out_valid) begin
        total++; if (e !== 17 + 16 * nres) $display("FAIL sparse_when: got edge %0d expected %0d", e, 17 + 16 * nres); else passed++;
        total++; if (rate !== 8'd4) $display("FAIL sparse_rate: got %0d expected 4", rate); else passed++;
        total++; if (isi !== 8'd4) $display("FAIL sparse_isi: got %0d expected 4", isi); else passed++;
        nres++;
      end
    end
    total++; if (nres !== 3) $display("FAIL sparse_count: got %0d expected 3", nres); else passed++;
  endtask

  task automatic test_win0();
    logic [4:0] pat;
    logic [7:0] exp_isi [5];
    pat = 5'b01101;
    exp_isi[0] = 8'd1; exp_isi[1] = 8'd1; exp_isi[2] = 8'd2; exp_isi[3] = 8'd1; exp_isi[4] = 8'd1;
    do_reset();
    win_len = 8'd0; out_ready = 1'b1; en = 1'b1; spike = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      spike = pat[i];
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL w0_valid[%0d]: got %0b expected 1", i, out_valid); else passed++;
      total++; if (rate !== {7'd0, pat[i]}) $display("FAIL w0_rate[%0d]: got %0d expected %0d", i, rate, pat[i]); else passed++;
      total++; if (isi !== exp_isi[i]) $display("FAIL w0_isi[%0d]: got %0d expected %0d", i, isi, exp_isi[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back_overrun();
    do_reset();
    win_len = 8'd3; out_ready = 1'b0; spike = 1'b1; en = 1'b1;
    tick();
    repeat (4) tick();
    total++; if (out_valid !== 1'b1) $display("FAIL ovr_valid1: got %0b expected 1", out_valid); else passed++;
    total++; if (rate !== 8'd4) $display("FAIL ovr_rate1: got %0d expected 4", rate); else passed++;
    spike = 1'b0;
    repeat (3) tick();
    total++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %0b expected 0", overrun); else passed++;
    tick();
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0b expected 1", overrun); else passed++;
    total++; if (rate !== 8'd4) $display("FAIL ovr_rate_held: got %0d expected 4", rate); else passed++;
    total++; if (isi !== 8'd1) $display("FAIL ovr_isi_held: got %0d expected 1", isi); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL ovr_valid2: got %0b expected 1", out_valid); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL ovr_drain: got %0b expected 0", out_valid); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b expected 1", overrun); else passed++;
  endtask

  task automatic test_en_drop_and_reset();
    logic stable;
    int   n;
    do_reset();
    win_len = 8'd7; out_ready = 1'b0; spike = 1'b1; en = 1'b1;
    tick();
    repeat (8) tick();
    total++; if (rate !== 8'd8) $display("FAIL drop_pre_rate: got %0d expected 8", rate); else passed++;
    repeat (5) tick();
    en = 1'b0;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %0b expected 0", busy); else passed++;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b1 || rate !== 8'd8 || isi !== 8'd1) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) $display("FAIL drop_hold: got %0b expected 1", stable); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL drop_overrun: got %0b expected 0", overrun); else passed++;

    en = 1'b1;
    repeat (3) tick();
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %0b expected 1", out_valid); else passed++;
    rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %0b expected 0", out_valid); else passed++;
    total++; if (rate !== 8'd0) $display("FAIL mid_rate: got %0d expected 0", rate); else passed++;
    total++; if (isi !== 8'd0) $display("FAIL mid_isi: got %0d expected 0", isi); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b expected 0", busy); else passed++;
    rst_n = 1'b1; win_len = 8'd3; out_ready = 1'b1; spike = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 5) $display("FAIL mid_fresh_latency: got %0d expected 5", n); else passed++;
    total++; if (rate !== 8'd4) $display("FAIL mid_fresh_rate: got %0d expected 4", rate); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; spike = 1'b0; out_ready = 1'b0; win_len = 8'd0;
    test_reset();
    test_periodic();
    test_saturate();
    test_sparse();
    test_win0();
    test_back_to_back_overrun();
    test_en_drop_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
